// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one rggen register bus between HOSTS requesters.
// Define RGGEN_BUS_ARBITER_TIMEOUT_EN to add a watchdog that fails stalled transfers.
module rggen_bus_arbiter #(
  parameter int HOSTS          = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [HOSTS-1:0]                i_valid,
  input  logic [2*HOSTS-1:0]              i_access,
  input  logic [HOSTS*ADDRESS_WIDTH-1:0]  i_address,
  input  logic [HOSTS*BUS_WIDTH-1:0]      i_write_data,
  input  logic [HOSTS*BUS_WIDTH/8-1:0]    i_strobe,
  output logic [HOSTS-1:0]                o_ready,
  output logic [2*HOSTS-1:0]              o_status,
  output logic [HOSTS*BUS_WIDTH-1:0]      o_read_data,
  output logic                            o_bus_valid,
  output logic [1:0]                      o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]        o_bus_address,
  output logic [BUS_WIDTH-1:0]            o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]          o_bus_strobe,
  input  logic                            i_bus_ready,
  input  logic [1:0]                      i_bus_status,
  input  logic [BUS_WIDTH-1:0]            i_bus_read_data
);

  localparam int GW = (HOSTS > 1) ? $clog2(HOSTS) : 1;
  localparam int SW = BUS_WIDTH / 8;

  if (HOSTS < 2) begin : g_bad_hosts
    $error("rggen_bus_arbiter: HOSTS must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("rggen_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state, state_next;
  logic [GW-1:0]   grant, grant_next;
  logic [GW-1:0]   pointer, pointer_next;
  logic [GW-1:0]   pick;
  logic            bus_valid;
  logic            done;
  logic            timeout;

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_count;

  // Held at zero while idle so every BUSY entry starts a fresh count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_count <= '0;
    end else if (state == IDLE) begin
      wd_count <= '0;
    end else if (!i_bus_ready) begin
      wd_count <= wd_count + 1'b1;
    end
  end

  assign timeout = (state == BUSY) && i_valid[grant] && !i_bus_ready &&
                   (wd_count == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // First requester at or after the pointer, wrapping modulo HOSTS.
  always_comb begin
    int   p;
    logic found;
    pick  = '0;
    found = 1'b0;
    p     = 0;
    for (int i = 0; i < HOSTS; i++) begin
      p = int'(pointer) + i;
      if (p >= HOSTS) p = p - HOSTS;
      if (!found && i_valid[GW'(p)]) begin
        pick  = GW'(p);
        found = 1'b1;
      end
    end
  end

  assign bus_valid        = (state == BUSY) && i_valid[grant] && !timeout;
  assign done             = (bus_valid && i_bus_ready) || timeout;
  assign o_bus_valid      = bus_valid;
  assign o_bus_access     = i_access[grant*2 +: 2];
  assign o_bus_address    = i_address[grant*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign o_bus_write_data = i_write_data[grant*BUS_WIDTH +: BUS_WIDTH];
  assign o_bus_strobe     = i_strobe[grant*SW +: SW];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      grant   <= '0;
      pointer <= '0;
    end else begin
      state   <= state_next;
      grant   <= grant_next;
      pointer <= pointer_next;
    end
  end

  always_comb begin
    state_next   = state;
    grant_next   = grant;
    pointer_next = pointer;
    case (state)
      IDLE: begin
        if (|i_valid) begin
          state_next = BUSY;
          grant_next = pick;
        end
      end
      BUSY: begin
        if (done) begin
          state_next   = IDLE;
          pointer_next = (grant == GW'(HOSTS - 1)) ? '0 : grant + 1'b1;
        end else if (!i_valid[grant]) begin
          // Requester withdrew mid-transfer: abandon without moving priority.
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_ready     = '0;
    o_status    = '0;
    o_read_data = '0;
    if (done) begin
      o_ready[grant]                           = 1'b1;
      o_status[grant*2 +: 2]                   = timeout ? 2'b10 : i_bus_status;
      o_read_data[grant*BUS_WIDTH +: BUS_WIDTH] = timeout ? '0 : i_bus_read_data;
    end
  end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed bench for rggen_bus_arbiter with three hosts.
module tb_rggen_bus_arbiter;
  localparam int H   = 3;
  localparam int AW  = 8;
  localparam int BW  = 32;
  localparam int SW  = BW / 8;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [H-1:0]      valid;
  logic [2*H-1:0]    access;
  logic [H*AW-1:0]   address;
  logic [H*BW-1:0]   wdata;
  logic [H*SW-1:0]   strobe;
  logic [H-1:0]      ready;
  logic [2*H-1:0]    status;
  logic [H*BW-1:0]   rdata;
  logic              bus_valid;
  logic [1:0]        bus_access;
  logic [AW-1:0]     bus_address;
  logic [BW-1:0]     bus_wdata;
  logic [SW-1:0]     bus_strobe;
  logic              bus_ready;
  logic [1:0]        bus_status;
  logic [BW-1:0]     bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  rggen_bus_arbiter #(
    .HOSTS(H), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_valid(valid), .i_access(access), .i_address(address),
    .i_write_data(wdata), .i_strobe(strobe),
    .o_ready(ready), .o_status(status), .o_read_data(rdata),
    .o_bus_valid(bus_valid), .o_bus_access(bus_access), .o_bus_address(bus_address),
    .o_bus_write_data(bus_wdata), .o_bus_strobe(bus_strobe),
    .i_bus_ready(bus_ready), .i_bus_status(bus_status), .i_bus_read_data(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = '0; bus_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = '0; bus_ready = 1'b0;
    tick();
    n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL rst_bus_valid: got %b want 0", bus_valid); end
    n_cmp++; if (ready !== 3'b000) begin n_bad++; $display("FAIL rst_ready: got %b want 000", ready); end
    n_cmp++; if (status !== 6'b0 || rdata !== '0) begin n_bad++; $display("FAIL rst_resp: got st=%b rd=%h want 0", status, rdata); end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    // serve host0 so the pointer moves to 1
    valid = 3'b001; bus_ready = 1'b1; bus_status = 2'b00;
    tick();
    n_cmp++; if (ready !== 3'b001) begin n_bad++; $display("FAIL rm_first_ready: got %b want 001", ready); end
    tick();
    valid = 3'b011; bus_ready = 1'b0;
    tick();
    n_cmp++; if (bus_valid !== 1'b1 || bus_address !== 8'hA1) begin n_bad++; $display("FAIL rm_grant1: got v=%b a=%h want 1/a1", bus_valid, bus_address); end
    tick();
    n_cmp++; if (ready !== 3'b000) begin n_bad++; $display("FAIL rm_stall_ready: got %b want 000", ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus_valid !== 1'b0 || ready !== 3'b000) begin n_bad++; $display("FAIL rm_after_rst: got v=%b r=%b want 0/000", bus_valid, ready); end
    tick();
    n_cmp++; if (bus_valid !== 1'b1 || bus_address !== 8'hA0) begin n_bad++; $display("FAIL rm_regrant0: got v=%b a=%h want 1/a0", bus_valid, bus_address); end
    bus_ready = 1'b1; #1;
    n_cmp++; if (ready !== 3'b001) begin n_bad++; $display("FAIL rm_final_ready: got %b want 001", ready); end
    tick();
    valid = '0; bus_ready = 1'b0;
    tick();
  endtask

  task automatic test_single_zero_wait();
    do_reset();
    address[15:8] = 8'h10;
    bus_rdata = 32'h1234_5678; bus_status = 2'b00; bus_ready = 1'b1; valid = 3'b010;
    #1;
    n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL sz_cycle0_valid: got %b want 0", bus_valid); end
    tick();
    n_cmp++; if (bus_valid !== 1'b1 || bus_address !== 8'h10) begin n_bad++; $display("FAIL sz_bus: got v=%b a=%h want 1/10", bus_valid, bus_address); end
    n_cmp++; if (bus_access !== 2'b10 || bus_wdata !== 32'h1111_1111 || bus_strobe !== 4'h3) begin n_bad++; $display("FAIL sz_fields: got acc=%b wd=%h st=%h want 10/11111111/3", bus_access, bus_wdata, bus_strobe); end
    n_cmp++; if (ready !== 3'b010) begin n_bad++; $display("FAIL sz_ready: got %b want 010", ready); end
    n_cmp++; if (rdata !== {32'h0, 32'h1234_5678, 32'h0}) begin n_bad++; $display("FAIL sz_rdata: got %h want 0/12345678/0", rdata); end
    n_cmp++; if (status !== 6'b0) begin n_bad++; $display("FAIL sz_status: got %b want 000000", status); end
    tick();
    valid = '0; #1;
    n_cmp++; if (ready !== 3'b000 || rdata !== '0) begin n_bad++; $display("FAIL sz_idle: got r=%b rd=%h want 000/0", ready, rdata); end
    address[15:8] = 8'hA1; bus_ready = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy;
    logic [5:0] exp_st;
    do_reset();
    valid = 3'b111; bus_ready = 1'b1; bus_status = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_rdy = 3'b001 << (i % 3);
      exp_st  = 6'b000001 << (2 * (i % 3));
      n_cmp++; if (bus_address !== 8'hA0 + 8'(i % 3) || ready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant%0d: got a=%h r=%b want %h/%b", i, bus_address, ready, 8'hA0 + 8'(i % 3), exp_rdy); end
      n_cmp++; if (status !== exp_st) begin n_bad++; $display("FAIL rr_status%0d: got %b want %b", i, status, exp_st); end
      tick();
      n_cmp++; if (ready !== 3'b000 || bus_valid !== 1'b0) begin n_bad++; $display("FAIL rr_gap%0d: got r=%b v=%b want 000/0", i, ready, bus_valid); end
    end
    valid = '0; bus_ready = 1'b0;
    tick();
  endtask

  task automatic test_wrap_skip();
    do_reset();
    valid = 3'b010; bus_ready = 1'b1; bus_status = 2'b00;
    tick();
    n_cmp++; if (bus_address !== 8'hA1 || ready !== 3'b010) begin n_bad++; $display("FAIL ws_first: got a=%h r=%b want a1/010", bus_address, ready); end
    tick();
    tick();
    n_cmp++; if (bus_address !== 8'hA1 || ready !== 3'b010) begin n_bad++; $display("FAIL ws_skip: got a=%h r=%b want a1/010", bus_address, ready); end
    valid = 3'b111;
    tick();
    tick();
    n_cmp++; if (bus_address !== 8'hA2 || ready !== 3'b100) begin n_bad++; $display("FAIL ws_ptr2: got a=%h r=%b want a2/100", bus_address, ready); end
    valid = '0; bus_ready = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    valid = 3'b011; bus_ready = 1'b0; bus_status = 2'b10; bus_rdata = 32'hDEAD_BEEF;
    tick();
    for (int c = 1; c <= 5; c++) begin
      n_cmp++; if (ready !== 3'b000 || bus_valid !== 1'b1 || bus_address !== 8'hA0) begin n_bad++; $display("FAIL st_wait%0d: got r=%b v=%b a=%h want 000/1/a0", c, ready, bus_valid, bus_address); end
      tick();
    end
    bus_ready = 1'b1; #1;
    n_cmp++; if (ready !== 3'b001 || status !== 6'b000010) begin n_bad++; $display("FAIL st_done: got r=%b st=%b want 001/000010", ready, status); end
    n_cmp++; if (rdata !== {64'h0, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL st_rdata: got %h want deadbeef in host0", rdata); end
    valid = 3'b010;
    tick();
    tick();
    n_cmp++; if (bus_address !== 8'hA1 || ready !== 3'b010 || status !== 6'b001000) begin n_bad++; $display("FAIL st_next: got a=%h r=%b st=%b want a1/010/001000", bus_address, ready, status); end
    valid = '0; bus_ready = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    do_reset();
    valid = 3'b001; bus_ready = 1'b0;
    tick();
    valid = 3'b000; #1;
    n_cmp++; if (bus_valid !== 1'b0 || ready !== 3'b000) begin n_bad++; $display("FAIL wd_drop: got v=%b r=%b want 0/000", bus_valid, ready); end
    tick();
    valid = 3'b101; #1;
    n_cmp++; if (bus_valid !== 1'b0) begin n_bad++; $display("FAIL wd_idle: got v=%b want 0", bus_valid); end
    tick();
    n_cmp++; if (bus_address !== 8'hA0 || bus_valid !== 1'b1) begin n_bad++; $display("FAIL wd_ptr_kept: got a=%h v=%b want a0/1", bus_address, bus_valid); end
    valid = '0;
    tick();
  endtask

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    valid = 3'b011; bus_ready = 1'b0; bus_status = 2'b00; bus_rdata = 32'h55AA_55AA;
    tick();
    for (int c = 1; c < TMO; c++) begin
      n_cmp++; if (ready !== 3'b000 || bus_valid !== 1'b1) begin n_bad++; $display("FAIL to_wait%0d: got r=%b v=%b want 000/1", c, ready, bus_valid); end
      tick();
    end
    n_cmp++; if (ready !== 3'b001 || status !== 6'b000010 || rdata !== '0 || bus_valid !== 1'b0) begin n_bad++; $display("FAIL to_fire: got r=%b st=%b rd=%h v=%b want 001/000010/0/0", ready, status, rdata, bus_valid); end
    valid = 3'b010;
    tick();
    tick();
    n_cmp++; if (bus_address !== 8'hA1 || bus_valid !== 1'b1) begin n_bad++; $display("FAIL to_next: got a=%h v=%b want a1/1", bus_address, bus_valid); end
    valid = '0;
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; valid = '0; bus_ready = 1'b0; bus_status = 2'b00; bus_rdata = '0;
    access  = {2'b11, 2'b10, 2'b01};
    address = {8'hA2, 8'hA1, 8'hA0};
    wdata   = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    strobe  = {4'h7, 4'h3, 4'h1};
    test_reset();
    test_reset_mid();
    test_single_zero_wait();
    test_round_robin();
    test_wrap_skip();
    test_stall();
    test_withdraw();
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rggen_bus_arbiter.md
Name: rggen_bus_arbiter

Overview:
- Shares one downstream register bus (valid/access/address/write_data/strobe → ready/status/read_data, rggen bus protocol) between HOSTS upstream requesters.
- Sits in front of rggen_adapter_common when several bus adapters, such as a CPU-side AXI4-Lite path and a debug path, target one register block.
- Arbitration is round-robin with a registered grant. The grant is locked until the downstream transaction completes.

Parameters:
- HOSTS, 2, number of upstream requesters (≥2).
- ADDRESS_WIDTH, 8, address width in bits.
- BUS_WIDTH, 32, data width in bits. Strobe width is BUS_WIDTH/8.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles, ≥2. Used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  HOSTS  per-host request valid.
- i_access  in  2*HOSTS  per-host rggen_access. Host k occupies [2k+1:2k].
- i_address  in  HOSTS*ADDRESS_WIDTH  per-host address.
- i_write_data  in  HOSTS*BUS_WIDTH  per-host write data.
- i_strobe  in  HOSTS*BUS_WIDTH/8  per-host byte strobe.
- o_ready  out  HOSTS  per-host completion pulse.
- o_status  out  2*HOSTS  per-host rggen_status.
- o_read_data  out  HOSTS*BUS_WIDTH  per-host read data.
- o_bus_valid  out  1  downstream valid.
- o_bus_access  out  2  downstream access.
- o_bus_address  out  ADDRESS_WIDTH  downstream address.
- o_bus_write_data  out  BUS_WIDTH  downstream write data.
- o_bus_strobe  out  BUS_WIDTH/8  downstream strobe.
- i_bus_ready  in  1  downstream completion.
- i_bus_status  in  2  downstream status.
- i_bus_read_data  in  BUS_WIDTH  downstream read data.

Behaviour:
- Registered state:
  - FSM state: IDLE or BUSY.
  - grant index: $clog2(HOSTS) bits.
  - priority pointer: same width.
- Reset (i_rst high at a clock edge):
  - state=IDLE, grant=0, pointer=0.
  - All o_ready=0. o_bus_valid=0.
  - Reset wins over every other event, including a transaction in flight. The aborted host sees no o_ready.
- Downstream data outputs always carry the granted host's fields (mux by grant). They are don't-care while o_bus_valid=0.
- IDLE:
  - o_bus_valid=0, o_ready=0.
  - If any i_valid is high, grant ← first requesting host scanning pointer, pointer+1, …, wrapping modulo HOSTS. State ← BUSY.
  - If no i_valid is high, stay in IDLE.
- BUSY:
  - o_bus_valid = i_valid[grant].
  - When i_bus_ready=1 and o_bus_valid=1:
    - o_ready[grant]=1 in the same cycle (combinational).
    - o_status[grant]=i_bus_status and o_read_data[grant]=i_bus_read_data.
    - Next state ← IDLE. pointer ← (grant+1) mod HOSTS, with explicit wrap when HOSTS is not a power of two.
  - If i_valid[grant] drops before completion (protocol violation): state ← IDLE, no o_ready, pointer unchanged.
- Non-granted hosts:
  - o_ready=0. o_status and o_read_data are driven 0.
  - The granted host's o_status and o_read_data are also 0 when o_ready=0.
- Timing:
  - Minimum latency: i_valid rise at cycle 0 → o_bus_valid at cycle 1 → o_ready at cycle 1 if the downstream is zero-wait.
  - Back-to-back grants have one IDLE cycle between them. Sustained throughput is one transaction per 2 cycles.
- Fairness:
  - Every continuously requesting host is served within HOSTS grants.
  - The just-served host has lowest priority in the next arbitration.
- Upstream hosts hold i_valid and fields stable until o_ready, per the rggen bus protocol. The arbiter adds no buffering.

Optional Feature:
- Macro: RGGEN_BUS_ARBITER_TIMEOUT_EN.
- When defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit watchdog counter clears on entry to BUSY and increments each BUSY cycle without i_bus_ready.
  - When the counter reaches TIMEOUT_CYCLES-1 with no i_bus_ready, the arbiter completes the transaction itself:
    - o_ready[grant]=1, o_status[grant]=RGGEN_SLAVE_ERROR (2'b10), o_read_data[grant]='0.
    - o_bus_valid is forced to 0 that cycle. State ← IDLE and the pointer advances.
  - The counter resets to 0 on i_rst.
- When not defined: no counter, and BUSY waits indefinitely for i_bus_ready. TIMEOUT_CYCLES is unused.

Test Plan:
- Reset mid-transaction. HOSTS=2: host0 write in BUSY with downstream stalled, assert i_rst for 1 cycle → next cycle o_bus_valid=0, o_ready=2'b00, then host0 re-granted with pointer 0.
- Single host, zero-wait. Host1 read of address 0x10, i_bus_read_data=0x12345678, status OKAY → o_bus_valid at cycle 1, o_ready=2'b10 and o_read_data[1]=0x12345678 at cycle 1.
- Round-robin. HOSTS=3, all hosts valid continuously, zero-wait → grant order 0,1,2,0,1,2. o_ready pulses every 2nd cycle.
- Wrap and skip. HOSTS=3, pointer=2, only host1 valid → host1 granted; pointer becomes 2 after completion.
- Downstream stall. i_bus_ready low 5 cycles then high, status 2'b10 → o_ready only on cycle 6 with o_status=2'b10; other hosts stay blocked throughout.
- Timeout (macro defined, TIMEOUT_CYCLES=4). Downstream never ready → o_ready at 4th BUSY cycle with o_status=2'b10 and o_read_data=0, o_bus_valid=0 that cycle, next host served.
